// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_gen
//  Description : Raster timing generator. Runs horizontal/vertical counters
//                over an H_TOT x V_TOT frame and decodes them into registered
//                HSYNC/VSYNC, VIDEO_ON, PIX_X/PIX_Y and a FRAME_TICK pulse at
//                the start of vertical blanking.
//                Optional macro VGA_FRAME_CNT_EN adds an 8-bit FRAME_CNT
//                output that increments with each FRAME_TICK.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int   H_VIS    = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_VIS    = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       CLK25,
    input  logic       RST,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       VIDEO_ON,
    output logic [9:0] PIX_X,
    output logic [9:0] PIX_Y,
`ifdef VGA_FRAME_CNT_EN
    output logic [7:0] FRAME_CNT,
`endif
    output logic       FRAME_TICK
);

    // Counter limits and decode boundaries, all at the 10-bit counter width
    localparam logic [9:0] c_H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] c_V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] c_H_VIS    = 10'(H_VIS);
    localparam logic [9:0] c_V_VIS    = 10'(V_VIS);
    localparam logic [9:0] c_HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] c_HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] c_VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] c_VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic [9:0] r_pix_x;
    logic [9:0] r_pix_y;
    logic       r_frame_tick;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_hs_act;
    logic w_vs_act;
    logic w_vid;
    logic w_tick;

    // Decode of the current counter state; outputs register this one cycle later
    always_comb begin
        w_h_wrap = (r_h_cnt == c_H_LAST);
        w_v_wrap = (r_v_cnt == c_V_LAST);
        w_hs_act = (r_h_cnt >= c_HS_FIRST) && (r_h_cnt <= c_HS_LAST);
        w_vs_act = (r_v_cnt >= c_VS_FIRST) && (r_v_cnt <= c_VS_LAST);
        w_vid    = (r_h_cnt < c_H_VIS) && (r_v_cnt < c_V_VIS);
        w_tick   = (r_h_cnt == 10'd0) && (r_v_cnt == c_V_VIS);
    end

    // Raster counters: v advances only on the h wrap; both wrap on the same edge
    always_ff @(posedge CLK25) begin
        if (RST) begin
            r_h_cnt <= 10'd0;
            r_v_cnt <= 10'd0;
        end else begin
            r_h_cnt <= w_h_wrap ? 10'd0 : r_h_cnt + 10'd1;
            if (w_h_wrap) begin
                r_v_cnt <= w_v_wrap ? 10'd0 : r_v_cnt + 10'd1;
            end
        end
    end

    // Registered outputs; syncs idle at the inactive level, including in reset
    always_ff @(posedge CLK25) begin
        if (RST) begin
            r_hsync      <= ~SYNC_POL;
            r_vsync      <= ~SYNC_POL;
            r_video_on   <= 1'b0;
            r_pix_x      <= 10'd0;
            r_pix_y      <= 10'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_hsync      <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vsync      <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_video_on   <= w_vid;
            r_pix_x      <= r_h_cnt;
            r_pix_y      <= r_v_cnt;
            r_frame_tick <= w_tick;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    // Frame counter steps on the same edge that raises FRAME_TICK, wraps 255->0
    always_ff @(posedge CLK25) begin
        if (RST) begin
            r_frame_cnt <= 8'd0;
        end else if (w_tick) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign FRAME_CNT = r_frame_cnt;
`endif

    assign HSYNC      = r_hsync;
    assign VSYNC      = r_vsync;
    assign VIDEO_ON   = r_video_on;
    assign PIX_X      = r_pix_x;
    assign PIX_Y      = r_pix_y;
    assign FRAME_TICK = r_frame_tick;

endmodule
`default_nettype wire
